// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Bundle of core, DMA and data-memory signals around dmem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Core (pipeline M stage) side
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_done;
  logic          core_stall;

  // DMA / debug side
  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_done;

  // Data memory side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_done, core_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_rdata, dma_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_done, core_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_rdata, dma_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares a single-ported fixed-latency dmem between core and DMA.
//            Define DMEM_ARB_RR_EN for round-robin instead of core priority.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);

  localparam int              c_CW   = $clog2(MEM_LAT + 1);
  localparam logic [c_CW-1:0] c_LAT  = c_CW'(MEM_LAT);
  localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);
  localparam logic            c_CORE = 1'b0;
  localparam logic            c_DMA  = 1'b1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic            r_owner;
  logic [DW-1:0]   r_core_hold;
  logic [DW-1:0]   r_dma_hold;

  logic            w_core_pri;
  logic            w_idle;
  logic            w_issue;
  logic            w_grant_dma;
  logic            w_win_we;
  logic [AW-1:0]   w_win_addr;
  logic [DW-1:0]   w_win_wdata;
  logic            w_rd_done;
  logic            w_core_rd_done;
  logic            w_dma_rd_done;

`ifdef DMEM_ARB_RR_EN
  logic r_last_grant;

  // Core has priority only when the DMA port was granted last.
  assign w_core_pri = (r_last_grant == c_DMA);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= c_DMA;
    end else if (w_issue) begin
      r_last_grant <= w_grant_dma;
    end
  end
`else
  assign w_core_pri = 1'b1;
`endif

  // rst_n gates issue so nothing reaches dmem while reset is asserted.
  assign w_idle      = rst_n && (r_state == S_IDLE);
  assign w_issue     = w_idle && (bus.core_req || bus.dma_req);
  assign w_grant_dma = bus.dma_req && !(bus.core_req && w_core_pri);

  assign w_win_we    = w_grant_dma ? bus.dma_we    : bus.core_we;
  assign w_win_addr  = w_grant_dma ? bus.dma_addr  : bus.core_addr;
  assign w_win_wdata = w_grant_dma ? bus.dma_wdata : bus.core_wdata;

  assign w_rd_done      = (r_state == S_BUSY) && (r_cnt == c_ONE);
  assign w_core_rd_done = w_rd_done && (r_owner == c_CORE);
  assign w_dma_rd_done  = w_rd_done && (r_owner == c_DMA);

  assign bus.mem_en    = w_issue;
  assign bus.mem_we    = w_issue && w_win_we;
  assign bus.mem_addr  = w_issue ? w_win_addr  : '0;
  assign bus.mem_wdata = w_issue ? w_win_wdata : '0;

  assign bus.core_done  = (w_issue && !w_grant_dma && w_win_we) || w_core_rd_done;
  assign bus.dma_done   = (w_issue &&  w_grant_dma && w_win_we) || w_dma_rd_done;
  assign bus.core_stall = bus.core_req && !bus.core_done;

  assign bus.core_rdata = w_core_rd_done ? bus.mem_rdata : r_core_hold;
  assign bus.dma_rdata  = w_dma_rd_done  ? bus.mem_rdata : r_dma_hold;

  // Writes finish in the issue cycle; only reads occupy BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner     <= c_CORE;
      r_core_hold <= '0;
      r_dma_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue && !w_win_we) begin
            r_state <= S_BUSY;
            r_cnt   <= c_LAT;
            r_owner <= w_grant_dma;
          end
        end
        S_BUSY: begin
          if (r_cnt == c_ONE) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            if (r_owner == c_DMA) begin
              r_dma_hold <= bus.mem_rdata;
            end else begin
              r_core_hold <= bus.mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - c_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter (MEM_LAT=2 and MEM_LAT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam int LAT = 2;
  localparam int NB  = 7;

  typedef struct {
    int          cyc;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   T;
  int   n_chk;
  int   n_err;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  dmem_arbiter_if #(.AW(32), .DW(32)) bus  ();
  dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Fixed-latency memory models; unwritten words read as A50000xx.
  logic [31:0] mem  [0:255];
  bit          wr   [0:255];
  logic [31:0] pd   [1:LAT];
  bit          pv   [1:LAT];
  logic [31:0] mem1 [0:255];
  logic [31:0] rd1;

  function automatic logic [31:0] rd_word(input logic [7:0] a);
    return wr[a] ? mem[a] : {24'hA50000, a};
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      wr[bus.mem_addr[7:0]]  <= 1'b1;
    end
    pd[1] <= rd_word(bus.mem_addr[7:0]);
    pv[1] <= bus.mem_en && !bus.mem_we;
    for (int i = 2; i <= LAT; i++) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
    if (bus1.mem_en && bus1.mem_we) mem1[bus1.mem_addr[7:0]] <= bus1.mem_wdata;
    rd1 <= mem1[bus1.mem_addr[7:0]];
  end
  assign bus.mem_rdata  = pv[LAT] ? pd[LAT] : 32'hBAD0_BAD0;
  assign bus1.mem_rdata = rd1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit done_of(input int p);
    case (p)
      0:       return bus.core_done;
      1:       return bus.dma_done;
      default: return bus1.dma_done;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push the expected completion, raise the request, hold it until done.
  task automatic op(input int p, input bit we, input logic [31:0] addr,
                    input logic [31:0] wdata, input int exp_cyc, input logic [31:0] exp_rd);
    exp_t e;
    bit   got;
    e.cyc = exp_cyc; e.rd = !we; e.data = exp_rd;
    case (p)
      0: begin
        q0.push_back(e);
        bus.core_we = we; bus.core_addr = addr; bus.core_wdata = wdata; bus.core_req = 1'b1;
      end
      1: begin
        q1.push_back(e);
        bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata; bus.dma_req = 1'b1;
      end
      default: begin
        q2.push_back(e);
        bus1.dma_we = we; bus1.dma_addr = addr; bus1.dma_wdata = wdata; bus1.dma_req = 1'b1;
      end
    endcase
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = done_of(p);
    end
    if (!got) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout port%0d: no done, expected at cycle %0d", p, exp_cyc);
    end
    tick();
    case (p)
      0:       bus.core_req = 1'b0;
      1:       bus.dma_req  = 1'b0;
      default: bus1.dma_req = 1'b0;
    endcase
  endtask

  task automatic sb_pop(input int p, input logic [31:0] data);
    exp_t e;
    bit   have;
    n_chk++;
    have = 1'b0;
    case (p)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_err++;
      $display("FAIL sb_port%0d: unexpected done at cycle %0d", p, cyc);
    end else if (e.cyc != cyc || (e.rd && data !== e.data)) begin
      n_err++;
      $display("FAIL sb_port%0d: done at cycle %0d data %h, expected cycle %0d data %h",
               p, cyc, data, e.cyc, e.data);
    end
  endtask

  bit prev_rd0;
  bit prev_rd1;
  always @(negedge clk) begin
    if (bus.core_done)  sb_pop(0, bus.core_rdata);
    if (bus.dma_done)   sb_pop(1, bus.dma_rdata);
    if (bus1.dma_done)  sb_pop(2, bus1.dma_rdata);
    if (prev_rd0) chk("m0_no_issue_after_read", {31'd0, bus.mem_en}, 32'd0);
    if (prev_rd1) chk("m1_no_issue_after_read", {31'd0, bus1.mem_en}, 32'd0);
    prev_rd0 <= bus.mem_en && !bus.mem_we;
    prev_rd1 <= bus1.mem_en && !bus1.mem_we;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0;
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
    bus.dma_req  = 0; bus.dma_we  = 0; bus.dma_addr  = 0; bus.dma_wdata  = 0;
    bus1.core_req = 0; bus1.core_we = 0; bus1.core_addr = 0; bus1.core_wdata = 0;
    bus1.dma_req  = 0; bus1.dma_we  = 0; bus1.dma_addr  = 0; bus1.dma_wdata  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_en",     {31'd0, bus.mem_en},     32'd0);
    chk("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
    chk("rst_mem_addr",   bus.mem_addr,            32'd0);
    chk("rst_core_done",  {31'd0, bus.core_done},  32'd0);
    chk("rst_dma_done",   {31'd0, bus.dma_done},   32'd0);
    chk("rst_core_stall", {31'd0, bus.core_stall}, 32'd0);
    chk("rst_core_rdata", bus.core_rdata,          32'd0);
    chk("rst_dma_rdata",  bus.dma_rdata,           32'd0);
    tick();
    rst_n = 1'b1;

    // Core store completes in its issue cycle.
    T = cyc;
    fork
      op(0, 1'b1, 32'h10, 32'hDEADBEEF, T, 32'h0);
      begin
        @(negedge clk);
        chk("st_mem_en",     {31'd0, bus.mem_en},     32'd1);
        chk("st_mem_we",     {31'd0, bus.mem_we},     32'd1);
        chk("st_mem_addr",   bus.mem_addr,            32'h10);
        chk("st_mem_wdata",  bus.mem_wdata,           32'hDEADBEEF);
        chk("st_core_stall", {31'd0, bus.core_stall}, 32'd0);
      end
    join

    // Core load: stall during latency, data held afterwards.
    T = cyc;
    fork
      op(0, 1'b0, 32'h10, 32'h0, T + 2, 32'hDEADBEEF);
      begin
        @(negedge clk);
        chk("ld_stall_T",  {31'd0, bus.core_stall}, 32'd1);
        chk("ld_mem_en_T", {31'd0, bus.mem_en},     32'd1);
        chk("ld_mem_we_T", {31'd0, bus.mem_we},     32'd0);
        @(negedge clk);
        chk("ld_stall_T1",  {31'd0, bus.core_stall}, 32'd1);
        chk("ld_mem_en_T1", {31'd0, bus.mem_en},     32'd0);
      end
    join
    tick(); tick();
    @(negedge clk);
    chk("ld_hold_T5", bus.core_rdata, 32'hDEADBEEF);
    tick();

    // Simultaneous loads; under round-robin the core was granted last.
    T = cyc;
    fork
      op(0, 1'b0, 32'h10, 32'h0, RR ? T + 5 : T + 2, 32'hDEADBEEF);
      op(1, 1'b0, 32'h24, 32'h0, RR ? T + 2 : T + 5, 32'hA5000024);
      begin
        @(negedge clk);
        chk("cont_first_addr", bus.mem_addr, RR ? 32'h24 : 32'h10);
      end
    join
    tick();
    chk("cont_dma_hold", bus.dma_rdata, 32'hA5000024);

    // Lone DMA write leaves the DMA as last grant before the starvation run.
    T = cyc;
    op(1, 1'b1, 32'h30, 32'h0000CAFE, T, 32'h0);

    T = cyc;
    fork
      begin
        for (int k = 0; k < NB; k++)
          op(0, 1'b0, 32'h40 + 4 * k, 32'h0, RR ? T + 6 * k + 2 : T + 3 * k + 2,
             32'hA5000040 + 4 * k);
      end
      begin
        for (int j = 0; j < NB; j++)
          op(1, 1'b0, 32'h80 + 4 * j, 32'h0, RR ? T + 6 * j + 5 : T + 3 * NB + 3 * j + 2,
             32'hA5000080 + 4 * j);
      end
    join
    tick();

    // Reset during a core load discards it; the held request re-issues.
    T = cyc;
    fork
      op(0, 1'b0, 32'h44, 32'h0, T + 4, 32'hA5000044);
      begin
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_mem_en",     {31'd0, bus.mem_en},     32'd0);
        chk("mrst_core_done",  {31'd0, bus.core_done},  32'd0);
        chk("mrst_core_rdata", bus.core_rdata,          32'd0);
        chk("mrst_dma_rdata",  bus.dma_rdata,           32'd0);
        chk("mrst_core_stall", {31'd0, bus.core_stall}, 32'd1);
        tick();
        rst_n = 1'b1;
      end
    join
    tick();
    chk("mrst_core_hold", bus.core_rdata, 32'hA5000044);

    // MEM_LAT=1 instance: alternating DMA write / read.
    T = cyc;
    op(2, 1'b1, 32'h30, 32'h0BADF00D, T,     32'h0);
    op(2, 1'b0, 32'h30, 32'h0,        T + 2, 32'h0BADF00D);
    op(2, 1'b1, 32'h34, 32'h11112222, T + 3, 32'h0);
    op(2, 1'b0, 32'h34, 32'h0,        T + 5, 32'h11112222);
    tick();
    chk("l1_dma_hold", bus1.dma_rdata, 32'h11112222);

    repeat (3) tick();
    chk("sb_core_drained", q0.size(), 32'd0);
    chk("sb_dma_drained",  q1.size(), 32'd0);
    chk("sb_dma1_drained", q2.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
